// File: rtl/pixel_assembler.sv
// pixel_assembler: shifts decoded bits into GRB pixel words, queues them with frame index, flags frame boundaries.
module pixel_assembler #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int INDEX_WIDTH    = 10
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_decode_bit,
  input  logic                      i_shift_en,
  input  logic                      i_treset,
  output logic [BITS_PER_PIXEL-1:0] o_pixel_data,
  output logic [INDEX_WIDTH-1:0]    o_pixel_index,
  output logic                      o_pixel_valid,
  input  logic                      i_pixel_ready,
  output logic                      o_frame_end,
  output logic                      o_frame_err,
  output logic                      o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BITS_PER_PIXEL);
  localparam int EW = BITS_PER_PIXEL + INDEX_WIDTH;
  logic [BITS_PER_PIXEL-1:0] shift_q, word;
  logic [CW-1:0]             bit_cnt;
  logic [INDEX_WIDTH-1:0]    pix_idx;
  logic                      treset_q, tr_edge, cap, complete, full, pop, push, head_ok;
  logic [AW:0]               wr_ptr, rd_ptr, rd_next;
  logic [EW-1:0]             mem [FIFO_DEPTH];
  assign tr_edge  = i_treset & ~treset_q;
  assign cap      = i_shift_en & ~tr_edge;
  assign complete = cap & (bit_cnt == CW'(BITS_PER_PIXEL - 1));
  assign word     = {shift_q[BITS_PER_PIXEL-2:0], i_decode_bit};
  assign pop      = o_pixel_valid & i_pixel_ready;
  assign full     = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
  assign push     = complete & (~full | pop);
  assign rd_next  = rd_ptr + {{AW{1'b0}}, pop};
  // Head becomes visible only once written on an earlier edge, giving the registered one-cycle latency.
  assign head_ok  = rd_next != wr_ptr;
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pix_idx, word};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q       <= '0;
      bit_cnt       <= '0;
      pix_idx       <= '0;
      treset_q      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_data  <= '0;
      o_pixel_index <= '0;
      o_frame_end   <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      treset_q    <= i_treset;
      o_frame_end <= tr_edge;
      o_frame_err <= tr_edge & (bit_cnt != '0);
      if (tr_edge) begin
        shift_q <= '0;
        bit_cnt <= '0;
        pix_idx <= '0;
      end else if (cap) begin
        shift_q <= word;
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        if (complete) pix_idx <= (pix_idx == '1) ? pix_idx : pix_idx + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      if (complete & full & ~pop) o_overflow <= 1'b1;
      o_pixel_valid <= head_ok;
      {o_pixel_index, o_pixel_data} <= head_ok ? mem[rd_next[AW-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_pixel_assembler.sv
// tb_pixel_assembler: directed vectors with hand-computed expectations for pixel_assembler.
module tb_pixel_assembler;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_decode_bit = 1'b0;
  logic        i_shift_en = 1'b0;
  logic        i_treset = 1'b0;
  logic        i_pixel_ready = 1'b0;
  logic [23:0] o_pixel_data;
  logic [9:0]  o_pixel_index;
  logic        o_pixel_valid, o_frame_end, o_frame_err, o_overflow;
  int          n_vec = 0;
  int          n_err = 0;
  int          fe_cnt = 0;
  int          fe_err_cnt = 0;
  logic [33:0] xq[$];
  pixel_assembler dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_decode_bit(i_decode_bit), .i_shift_en(i_shift_en),
    .i_treset(i_treset), .o_pixel_data(o_pixel_data), .o_pixel_index(o_pixel_index),
    .o_pixel_valid(o_pixel_valid), .i_pixel_ready(i_pixel_ready), .o_frame_end(o_frame_end),
    .o_frame_err(o_frame_err), .o_overflow(o_overflow)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) begin
    if (!i_reset && o_pixel_valid && i_pixel_ready) xq.push_back({o_pixel_index, o_pixel_data});
    if (o_frame_end) fe_cnt <= fe_cnt + 1;
    if (o_frame_err) fe_err_cnt <= fe_err_cnt + 1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    i_shift_en = 1'b0;
    i_treset = 1'b0;
    i_pixel_ready = 1'b0;
    step(2);
    i_reset = 1'b0;
    xq.delete();
  endtask
  task automatic send_bit(input logic b);
    i_decode_bit = b;
    i_shift_en = 1'b1;
    step();
    i_shift_en = 1'b0;
  endtask
  task automatic send_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic expect_xfer(input string tag, input logic [23:0] d, input logic [9:0] idx);
    logic [33:0] e;
    check({tag, "_avail"}, 64'(xq.size() > 0), 64'd1);
    if (xq.size() > 0) begin
      e = xq.pop_front();
      check({tag, "_data"}, 64'(e[23:0]), 64'(d));
      check({tag, "_idx"}, 64'(e[33:24]), 64'(idx));
    end
  endtask
  initial begin
    int fe0, fee0;
    logic [23:0] pv [5];
    for (int i = 0; i < 5; i++) pv[i] = {8'(i + 1), 16'hBEEF};
    // reset state
    do_reset();
    check("rst_valid", 64'(o_pixel_valid), 64'd0);
    check("rst_data", 64'(o_pixel_data), 64'd0);
    check("rst_index", 64'(o_pixel_index), 64'd0);
    check("rst_fend", 64'(o_frame_end), 64'd0);
    check("rst_ferr", 64'(o_frame_err), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    // single pixel and output latency
    i_pixel_ready = 1'b1;
    send_pixel(24'hA5C3F0);
    check("single_valid_n", 64'(o_pixel_valid), 64'd0);
    step();
    check("single_valid_n1", 64'(o_pixel_valid), 64'd1);
    check("single_data", 64'(o_pixel_data), 64'hA5C3F0);
    check("single_idx", 64'(o_pixel_index), 64'd0);
    step();
    check("single_drop", 64'(o_pixel_valid), 64'd0);
    check("single_count", 64'(xq.size()), 64'd1);
    expect_xfer("single", 24'hA5C3F0, 10'd0);
    // three-pixel frame then long treset
    do_reset();
    i_pixel_ready = 1'b1;
    send_pixel(24'h000001);
    send_pixel(24'hFFFFFF);
    send_pixel(24'h800000);
    step(3);
    fe0 = fe_cnt;
    fee0 = fe_err_cnt;
    i_treset = 1'b1;
    step(50);
    i_treset = 1'b0;
    step(2);
    check("frame_fend_cnt", 64'(fe_cnt - fe0), 64'd1);
    check("frame_ferr_cnt", 64'(fe_err_cnt - fee0), 64'd0);
    expect_xfer("frame_p0", 24'h000001, 10'd0);
    expect_xfer("frame_p1", 24'hFFFFFF, 10'd1);
    expect_xfer("frame_p2", 24'h800000, 10'd2);
    send_pixel(24'h00FF00);
    step(3);
    expect_xfer("frame_next", 24'h00FF00, 10'd0);
    // partial pixel truncated by boundary
    do_reset();
    i_pixel_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    i_treset = 1'b1;
    step();
    check("partial_fend", 64'(o_frame_end), 64'd1);
    check("partial_ferr", 64'(o_frame_err), 64'd1);
    step();
    check("partial_fend_pulse", 64'(o_frame_end), 64'd0);
    i_treset = 1'b0;
    send_pixel(24'h123456);
    step(3);
    expect_xfer("partial_next", 24'h123456, 10'd0);
    // backpressure and overflow
    do_reset();
    for (int i = 0; i < 4; i++) send_pixel(pv[i]);
    check("bp_ovf_4", 64'(o_overflow), 64'd0);
    send_pixel(pv[4]);
    check("bp_ovf_5", 64'(o_overflow), 64'd1);
    check("bp_hold_valid", 64'(o_pixel_valid), 64'd1);
    check("bp_hold_data", 64'(o_pixel_data), 64'(pv[0]));
    check("bp_hold_idx", 64'(o_pixel_index), 64'd0);
    i_pixel_ready = 1'b1;
    step(8);
    check("bp_count", 64'(xq.size()), 64'd4);
    for (int i = 0; i < 4; i++) expect_xfer($sformatf("bp_%0d", i), pv[i], 10'(i));
    i_treset = 1'b1;
    step(2);
    i_treset = 1'b0;
    check("bp_ovf_sticky", 64'(o_overflow), 64'd1);
    // full FIFO with ready in the completion cycle
    do_reset();
    check("full_ovf_rst", 64'(o_overflow), 64'd0);
    for (int i = 0; i < 4; i++) send_pixel(pv[i]);
    for (int i = 23; i > 0; i--) send_bit(pv[4][i]);
    i_pixel_ready = 1'b1;
    send_bit(pv[4][0]);
    i_pixel_ready = 1'b0;
    check("full_ovf", 64'(o_overflow), 64'd0);
    i_pixel_ready = 1'b1;
    step(8);
    check("full_count", 64'(xq.size()), 64'd5);
    for (int i = 0; i < 5; i++) expect_xfer($sformatf("full_%0d", i), pv[i], 10'(i));
    // reset mid-operation
    do_reset();
    send_pixel(24'hAAAAAA);
    send_pixel(24'h555555);
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    step();
    check("midrst_pre_valid", 64'(o_pixel_valid), 64'd1);
    fe0 = fe_cnt;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("midrst_valid", 64'(o_pixel_valid), 64'd0);
    check("midrst_fend", 64'(o_frame_end), 64'd0);
    xq.delete();
    i_pixel_ready = 1'b1;
    send_pixel(24'h0F0F0F);
    step(3);
    check("midrst_fend_cnt", 64'(fe_cnt - fe0), 64'd0);
    check("midrst_count", 64'(xq.size()), 64'd1);
    expect_xfer("midrst", 24'h0F0F0F, 10'd0);
    // boundary coincident with the 24th bit
    do_reset();
    i_pixel_ready = 1'b1;
    for (int i = 23; i > 0; i--) send_bit(pv[2][i]);
    i_treset = 1'b1;
    send_bit(pv[2][0]);
    check("coinc_fend", 64'(o_frame_end), 64'd1);
    check("coinc_ferr", 64'(o_frame_err), 64'd1);
    step(3);
    i_treset = 1'b0;
    check("coinc_valid", 64'(o_pixel_valid), 64'd0);
    check("coinc_count", 64'(xq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_assembler.md
Name: pixel_assembler

Overview:
- Downstream neighbour of the high-cycle decoder. Consumes its decoded-bit stream (decode_bit / shift_en / treset) and shifts bits MSB-first into 24-bit GRB pixel words.
- Queues each completed pixel, tagged with its position in the frame, in a small FIFO. The FIFO feeds the pixel sink (LED model / frame buffer writer) over a valid/ready handshake.
- Detects frame boundaries from the reset-low indication and flags partial pixels and overflow.

Parameters:
- BITS_PER_PIXEL, 24, bits per pixel word; MSB received first (G7 first).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- INDEX_WIDTH, 10, width of the pixel index within a frame.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, synchronous active-high reset.
- i_decode_bit, input, 1, decoded bit value; meaningful only when i_shift_en = 1.
- i_shift_en, input, 1, one-cycle strobe: a valid bit is present.
- i_treset, input, 1, level: line has been low longer than the latch threshold.
- o_pixel_data, output, BITS_PER_PIXEL, head-of-FIFO pixel {G,R,B}.
- o_pixel_index, output, INDEX_WIDTH, index of the head pixel within its frame.
- o_pixel_valid, output, 1, FIFO non-empty.
- i_pixel_ready, input, 1, sink accepts the head entry when o_pixel_valid & i_pixel_ready.
- o_frame_end, output, 1, one-cycle pulse on each frame boundary.
- o_frame_err, output, 1, one-cycle pulse coincident with o_frame_end when the boundary truncated a partial pixel.
- o_overflow, output, 1, sticky; set when a completed pixel is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, i_reset = 1 at a clock edge):
  - Shift register = 0, bit count = 0, pixel index = 0, FIFO emptied, treset-edge register = 0.
  - o_pixel_valid = 0, o_frame_end = 0, o_frame_err = 0, o_overflow = 0.
  - o_pixel_data and o_pixel_index = 0.
  - Reset mid-pixel or mid-frame discards all state; no pulses are generated.
- Bit capture, on i_shift_en = 1 with no treset rising edge in that cycle:
  - Shift register <= {shift[BITS_PER_PIXEL-2:0], i_decode_bit}.
  - Bit count increments.
- Pixel completion, when the BITS_PER_PIXEL-th bit is captured:
  - Bit count returns to 0 in that same cycle.
  - Entry {shifted word including the new bit, pixel index} is written to the FIFO.
  - Pixel index increments, saturating at 2^INDEX_WIDTH-1.
- Latency: completion at edge N makes o_pixel_valid = 1 after edge N+1 when the FIFO was empty. The FIFO output is registered; there is no combinational path from input to output.
- FIFO behaviour:
  - Simultaneous push and pop when full: both succeed, since the pop frees the slot in the same cycle.
  - Push when full with no pop: the entry is dropped, o_overflow is set (sticky until i_reset), and the pixel index still increments.
  - Pop when empty: ignored.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Handshake:
  - o_pixel_data and o_pixel_index stay stable while o_pixel_valid = 1 and i_pixel_ready = 0.
  - o_pixel_valid never drops without a transfer.
- Frame boundary:
  - Triggered by the rising edge of i_treset, detected against a registered copy. A held level gives a single event.
  - In the cycle after the edge: o_frame_end = 1 for one cycle.
  - o_frame_err = 1 in that same cycle if bit count was non-zero at the edge.
  - At the edge: bit count and shift register clear, pixel index clears to 0.
  - FIFO contents are retained and drain normally; each entry keeps its old-frame index.
- Simultaneous treset rising edge and i_shift_en: the boundary wins. The bit is discarded and not counted toward the error check.
- While i_treset stays high, further i_shift_en pulses are captured normally as the first bits of the next frame.
- Overflow remains set across frame boundaries.

Test Plan:
- Single pixel: 24 strobes carrying 0xA5C3F0 MSB-first, i_pixel_ready = 1 -> one transfer, o_pixel_data = 0xA5C3F0, o_pixel_index = 0, o_pixel_valid high 1 cycle after the 24th strobe.
- Frame of 3 pixels (0x000001, 0xFFFFFF, 0x800000), then i_treset high for 50 cycles -> indices 0, 1, 2 in order; exactly one o_frame_end pulse; o_frame_err = 0; the next frame's first pixel has index 0.
- Partial pixel: 10 strobes, then i_treset rises -> o_frame_end = 1 and o_frame_err = 1 in the same cycle; the following full 24 bits 0x123456 emit 0x123456 at index 0, not corrupted by the 10 stale bits.
- Backpressure: i_pixel_ready = 0, send 5 pixels with FIFO_DEPTH = 4 -> 4 entries held stable, o_overflow = 1 after the 5th completion; releasing ready yields indices 0–3; o_overflow stays 1 until i_reset.
- Full FIFO with ready asserted in the completion cycle -> both push and pop occur and o_overflow stays 0.
- Reset mid-operation: i_reset after 12 bits with 2 entries queued -> o_pixel_valid = 0 the next cycle, no o_frame_end; a fresh 24-bit pixel emerges at index 0.
- Simultaneous treset edge and shift_en on the 24th bit -> no pixel pushed, o_frame_err = 1.
